// File: rtl/ch_measure_pkg.sv
// Shared types and defaults for the channel measurement path (strobe generator and controller).
package ch_measure_pkg;

    localparam int unsigned TRIG_SYNC_STAGES_DEF = 2;
    localparam int unsigned DELAY_W_DEF          = 16;
    localparam int unsigned WIDTH_W_DEF          = 8;
    localparam int unsigned SETTLE_W_DEF         = 8;
    localparam int unsigned TIMEOUT_W_DEF        = 24;
    localparam int unsigned D_CODE_W             = 10;

    typedef logic [D_CODE_W-1:0] d_code_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_DELAY  = 3'd2,
        ST_PULSE  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } stb_gen_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, plus a rising-edge detector behind it.
module sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES-1:0] ff_q;
    logic              sync_d_q;

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            ff_q     <= '0;
            sync_d_q <= 1'b0;
        end else begin
            ff_q     <= {ff_q[STAGES-2:0], d_i};
            sync_d_q <= ff_q[STAGES-1];
        end
    end

    assign sync_o = ff_q[STAGES-1];
    assign rise_o = sync_o & ~sync_d_q;

endmodule

// File: rtl/ch_stb_gen.sv
// Comparator latch strobe generator: arm on request, fire after trigger + delay, report after settle.
// Optional arm timeout enabled by defining CH_STB_GEN_TIMEOUT_EN.
module ch_stb_gen
    import ch_measure_pkg::*;
#(
    parameter int unsigned TRIG_SYNC_STAGES = TRIG_SYNC_STAGES_DEF,
    parameter int unsigned DELAY_W          = DELAY_W_DEF,
    parameter int unsigned WIDTH_W          = WIDTH_W_DEF,
    parameter int unsigned SETTLE_W         = SETTLE_W_DEF,
    parameter int unsigned TIMEOUT_W        = TIMEOUT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 stb_req_i,
    output logic                 stb_valid_o,
    input  logic                 trig_i,
    input  logic [DELAY_W-1:0]   delay_i,
    input  logic [WIDTH_W-1:0]   width_i,
    input  logic [SETTLE_W-1:0]  settle_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic                 stb_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    stb_gen_state_t       state_q, state_d;
    logic                 trig_rise;
    logic                 unused_trig_sync;
    logic                 capture;
    logic [DELAY_W-1:0]   dly_q, dly_cnt_q;
    logic [WIDTH_W-1:0]   wid_q, pls_cnt_q, wid_eff;
    logic [SETTLE_W-1:0]  stl_q, stl_cnt_q;
    logic                 dly_done, pls_done, stl_done, to_hit;
    logic                 stb_q, busy_q, valid_q;

    sync_edge_det #(.STAGES(TRIG_SYNC_STAGES)) u_trig_sync (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .d_i    (trig_i),
        .sync_o (unused_trig_sync),
        .rise_o (trig_rise)
    );

    assign capture = (state_q == ST_IDLE) && stb_req_i;

    // Shadow copies so the controller may change settings once the request is taken
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            dly_q <= '0;
            wid_q <= '0;
            stl_q <= '0;
        end else if (capture) begin
            dly_q <= delay_i;
            wid_q <= width_i;
            stl_q <= settle_i;
        end
    end

    assign wid_eff  = (wid_q == '0) ? WIDTH_W'(1) : wid_q;
    assign dly_done = (dly_cnt_q == dly_q - DELAY_W'(1));
    assign pls_done = (pls_cnt_q == wid_eff - WIDTH_W'(1));
    assign stl_done = (stl_cnt_q == stl_q - SETTLE_W'(1));

    // Per-phase counters: cleared outside their phase, held once the terminal count is reached
    always_ff @(posedge clk_i) begin
        if (arst_i || state_q != ST_DELAY)   dly_cnt_q <= '0;
        else if (!dly_done)                  dly_cnt_q <= dly_cnt_q + DELAY_W'(1);

        if (arst_i || state_q != ST_PULSE)   pls_cnt_q <= '0;
        else if (!pls_done)                  pls_cnt_q <= pls_cnt_q + WIDTH_W'(1);

        if (arst_i || state_q != ST_SETTLE)  stl_cnt_q <= '0;
        else if (!stl_done)                  stl_cnt_q <= stl_cnt_q + SETTLE_W'(1);
    end

`ifdef CH_STB_GEN_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_q, to_cnt_q;
    logic                 timeout_q;

    assign to_hit = (state_q == ST_ARM) && (to_q != '0) && (to_cnt_q == to_q - TIMEOUT_W'(1));

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            to_q      <= '0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (capture) to_q <= timeout_i;
            if (state_q != ST_ARM)  to_cnt_q <= '0;
            else if (!to_hit)       to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
            // A trigger edge in the expiry cycle takes precedence over the timeout
            timeout_q <= to_hit && !trig_rise;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_i;
    assign to_hit         = 1'b0;
    assign timeout_o      = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (arst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (stb_req_i) state_d = ST_ARM;
            ST_ARM: begin
                if (trig_rise)   state_d = (dly_q == '0) ? ST_PULSE : ST_DELAY;
                else if (to_hit) state_d = ST_DONE;
            end
            ST_DELAY:  if (dly_done) state_d = ST_PULSE;
            ST_PULSE:  if (pls_done) state_d = (stl_q == '0) ? ST_DONE : ST_SETTLE;
            ST_SETTLE: if (stl_done) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            stb_q   <= (state_d == ST_PULSE);
            busy_q  <= (state_d != ST_IDLE);
            valid_q <= (state_d == ST_DONE);
        end
    end

    assign stb_o       = stb_q;
    assign busy_o      = busy_q;
    assign stb_valid_o = valid_q;

endmodule

// File: tb/tb_ch_stb_gen.sv
// Self-checking bench for ch_stb_gen: transaction-level timing model plus directed literal checks.
module tb_ch_stb_gen;

    localparam int unsigned NS = 2;
    localparam int unsigned DW = 16;
    localparam int unsigned WW = 8;
    localparam int unsigned SW = 8;
    localparam int unsigned TW = 24;
`ifdef CH_STB_GEN_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          arst_i = 1'b1;
    logic          stb_req_i = 1'b0;
    logic          trig_i = 1'b0;
    logic [DW-1:0] delay_i = '0;
    logic [WW-1:0] width_i = '0;
    logic [SW-1:0] settle_i = '0;
    logic [TW-1:0] timeout_i = '0;
    logic          stb_valid_o, stb_o, busy_o, timeout_o;

    always #5 clk_i = ~clk_i;

    ch_stb_gen #(
        .TRIG_SYNC_STAGES(NS), .DELAY_W(DW), .WIDTH_W(WW), .SETTLE_W(SW), .TIMEOUT_W(TW)
    ) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .stb_req_i   (stb_req_i),
        .stb_valid_o (stb_valid_o),
        .trig_i      (trig_i),
        .delay_i     (delay_i),
        .width_i     (width_i),
        .settle_i    (settle_i),
        .timeout_i   (timeout_i),
        .stb_o       (stb_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    int q_stb[$];
    int q_val[$];
    int q_to[$];
    int busy_last = -1;

    // Transaction model: phase 0 idle, 1 armed, 2 triggered, 3 timed-out report
    int m_phase = 0;
    int m_r, m_e, m_d, m_w, m_s, m_t, m_v;
    logic [NS:0] hist = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        logic e_stb, e_val, e_busy, e_to, edge_now;
        e_stb = 1'b0; e_val = 1'b0; e_busy = 1'b0; e_to = 1'b0;
        case (m_phase)
            1: e_busy = 1'b1;
            2: begin
                e_busy = 1'b1;
                e_stb  = (cyc >= m_e + 1 + m_d) && (cyc <= m_e + m_d + m_w);
                e_val  = (cyc == m_v);
            end
            3: begin e_busy = 1'b1; e_val = 1'b1; e_to = 1'b1; end
            default: ;
        endcase
        if (check_en) begin
            chk("model_stb",   64'(stb_o),       64'(e_stb));
            chk("model_valid", 64'(stb_valid_o), 64'(e_val));
            chk("model_busy",  64'(busy_o),      64'(e_busy));
            chk("model_to",    64'(timeout_o),   64'(e_to));
        end
        if (stb_o === 1'b1) q_stb.push_back(cyc);
        if (stb_valid_o === 1'b1) begin
            q_val.push_back(cyc);
            q_to.push_back(int'(timeout_o));
        end
        if (busy_o === 1'b1) busy_last = cyc;

        // Edge seen by the design this cycle: raw trig rose NS cycles earlier
        edge_now = hist[NS-1] & ~hist[NS];
        if (arst_i) m_phase = 0;
        else case (m_phase)
            0: if (stb_req_i) begin
                m_r = cyc;
                m_d = int'(delay_i);
                m_w = (width_i == '0) ? 1 : int'(width_i);
                m_s = int'(settle_i);
                m_t = TO_EN ? int'(timeout_i) : 0;
                m_phase = 1;
            end
            1: if (edge_now) begin
                m_e = cyc;
                m_v = cyc + 1 + m_d + m_w + m_s;
                m_phase = 2;
            end else if (m_t != 0 && cyc == m_r + m_t) begin
                m_v = cyc + 1;
                m_phase = 3;
            end
            default: if (cyc == m_v) m_phase = 0;
        endcase
        if (arst_i) hist = '0;
        else        hist = {hist[NS-1:0], trig_i};
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic to_cycle(input int t);
        while (cyc < t) tick();
    endtask

    task automatic cfg(input int d, input int w, input int s, input int t);
        delay_i = DW'(d); width_i = WW'(w); settle_i = SW'(s); timeout_i = TW'(t);
        q_stb.delete(); q_val.delete(); q_to.delete();
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (q_val.size() > 0) begin ok = 1'b1; break; end
            tick();
        end
        chk(name, 64'(ok), 64'(1));
    endtask

    function automatic int first_or(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    function automatic int last_or(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -1;
    endfunction

    task automatic request(output int r);
        stb_req_i = 1'b1; r = cyc; tick(); stb_req_i = 1'b0;
    endtask

    initial begin
        int r, c, e, a;
        tick(); tick();
        check_en = 1'b1;
        arst_i = 1'b0;
        chk("reset_stb",   64'(stb_o), 64'(0));
        chk("reset_valid", 64'(stb_valid_o), 64'(0));
        chk("reset_busy",  64'(busy_o), 64'(0));
        chk("reset_to",    64'(timeout_o), 64'(0));

        // Basic strobe
        cfg(5, 3, 4, 0);
        request(r); tick(); tick();
        trig_i = 1'b1; c = cyc; e = c + NS; tick();
        wait_valid("basic_wait", 100); repeat (3) tick();
        chk("basic_stb_len",   64'(q_stb.size()), 64'(3));
        chk("basic_stb_first", 64'(first_or(q_stb)), 64'(e + 6));
        chk("basic_stb_last",  64'(last_or(q_stb)), 64'(e + 8));
        chk("basic_valid_cnt", 64'(q_val.size()), 64'(1));
        chk("basic_valid_at",  64'(first_or(q_val)), 64'(e + 13));
        chk("basic_to_flag",   64'(first_or(q_to)), 64'(0));
        trig_i = 1'b0; repeat (NS + 3) tick();

        // All-zero settings
        cfg(0, 0, 0, 0);
        request(r);
        trig_i = 1'b1; c = cyc; e = c + NS; tick();
        wait_valid("zero_wait", 100); repeat (3) tick();
        chk("zero_stb_len",   64'(q_stb.size()), 64'(1));
        chk("zero_stb_at",    64'(first_or(q_stb)), 64'(e + 1));
        chk("zero_valid_at",  64'(first_or(q_val)), 64'(e + 2));
        chk("zero_busy_last", 64'(busy_last), 64'(e + 2));
        trig_i = 1'b0; repeat (NS + 3) tick();

        // Extra request and trigger edge while the strobe is high
        cfg(2, 4, 2, 0);
        request(r);
        trig_i = 1'b1; c = cyc; e = c + NS; tick();
        to_cycle(e + 1); trig_i = 1'b0;
        to_cycle(e + 3); trig_i = 1'b1;
        to_cycle(e + 4); stb_req_i = 1'b1; tick(); stb_req_i = 1'b0;
        wait_valid("ign_wait", 100); repeat (30) tick();
        chk("ign_stb_len",   64'(q_stb.size()), 64'(4));
        chk("ign_stb_first", 64'(first_or(q_stb)), 64'(e + 3));
        chk("ign_valid_cnt", 64'(q_val.size()), 64'(1));
        trig_i = 1'b0; repeat (NS + 3) tick();

        // Reset while counting the delay
        cfg(20, 3, 2, 0);
        request(r);
        trig_i = 1'b1; c = cyc; e = c + NS; tick();
        to_cycle(e + 5);
        trig_i = 1'b0; arst_i = 1'b1; a = cyc; tick(); arst_i = 1'b0;
        chk("rst_cycle", 64'(cyc), 64'(a + 1));
        chk("rst_stb",   64'(stb_o), 64'(0));
        chk("rst_busy",  64'(busy_o), 64'(0));
        chk("rst_valid", 64'(stb_valid_o), 64'(0));
        repeat (60) tick();
        chk("rst_no_valid", 64'(q_val.size()), 64'(0));
        chk("rst_no_stb",   64'(q_stb.size()), 64'(0));

        // Arm timeout with no trigger
        cfg(5, 3, 4, 100);
        request(r);
`ifdef CH_STB_GEN_TIMEOUT_EN
        wait_valid("to_wait", 300); repeat (2) tick();
        chk("to_valid_at", 64'(first_or(q_val)), 64'(r + 101));
        chk("to_flag",     64'(first_or(q_to)), 64'(1));
        chk("to_no_stb",   64'(q_stb.size()), 64'(0));
        chk("to_idle",     64'(busy_o), 64'(0));
`else
        repeat (1000) tick();
        chk("noto_busy",     64'(busy_o), 64'(1));
        chk("noto_no_valid", 64'(q_val.size()), 64'(0));
        arst_i = 1'b1; tick(); arst_i = 1'b0;
`endif
        repeat (3) tick();

        // Settings changed after acceptance must not matter
        cfg(5, 3, 4, 0);
        request(r);
        delay_i = DW'(50); tick();
        trig_i = 1'b1; c = cyc; e = c + NS; tick();
        wait_valid("cap_wait", 150); repeat (3) tick();
        chk("cap_stb_first", 64'(first_or(q_stb)), 64'(e + 6));
        chk("cap_valid_at",  64'(first_or(q_val)), 64'(e + 13));
        trig_i = 1'b0; repeat (NS + 3) tick();

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            stb_req_i = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) trig_i = ~trig_i;
            delay_i   = DW'($urandom_range(0, 12));
            width_i   = WW'($urandom_range(0, 5));
            settle_i  = SW'($urandom_range(0, 5));
            timeout_i = TW'($urandom_range(0, 40));
            arst_i    = ($urandom_range(0, 399) == 0);
            tick();
        end
        stb_req_i = 1'b0; arst_i = 1'b0; trig_i = 1'b0;
        repeat (60) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
